// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor
//   Watches a status bus for a programmed, ordered list of checkpoint values.
//   Each checkpoint must be held for STABLE consecutive cycles to count. A
//   per-step watchdog flags TIMEOUT, and with STRICT=1 a later checkpoint
//   seen early flags ORDER. The pass/fail verdict is sticky until the next
//   start or abort.
//
// Ports
//   clock      rising-edge clock
//   resetb     asynchronous active-low reset
//   sample     monitored bus (already synchronous to clock)
//   cfg_we     checkpoint write strobe (honoured in IDLE only)
//   cfg_addr   checkpoint index; addresses >= DEPTH are ignored
//   cfg_data   checkpoint value
//   seq_len    number of active checkpoints, latched on start (clamped to DEPTH)
//   tmo_limit  per-step cycle limit, latched on start; 0 disables the watchdog
//   start      arm from IDLE/PASS/FAIL
//   abort      return to IDLE with no verdict
//   busy       high while waiting for checkpoints
//   pass       sticky: every step matched
//   fail       sticky: failure detected
//   fail_code  0 none, 1 TIMEOUT, 2 ORDER
//   step       index of the checkpoint being awaited or failed on
module checkpoint_seq_monitor #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int TMO_W  = 24,
    parameter int STABLE = 2,
    parameter int STRICT = 0,
    localparam int IDXW  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [WIDTH-1:0] sample,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [IDXW-1:0]  seq_len,
    input  logic [TMO_W-1:0] tmo_limit,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [IDXW-1:0]  step
);

    localparam int CNT_W = $clog2(STABLE + 1);

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_TMO   = 2'd1;
    localparam logic [1:0] CODE_ORDER = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PASS,
        S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [IDXW-1:0]    step_q, step_d;
    logic [IDXW-1:0]    len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   wd_q, wd_d;
    logic [TMO_W-1:0]   lim_q, lim_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [1:0]         code_q, code_d;

    logic [WIDTH-1:0]   mem [DEPTH];

    logic [WIDTH-1:0]   exp_cur;
    logic               later_hit;
    logic               hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic               advance;
    logic               order_err;
    logic [TMO_W-1:0]   wd_inc;
    logic               timeout;
    logic [IDXW-1:0]    len_clamped;

    // Checkpoint storage; writes only land while idle so a running sequence
    // always sees a consistent list.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (state_q == S_IDLE && cfg_we) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (cfg_addr == IDXW'(k)) mem[k] <= cfg_data;
            end
        end
    end

    // Current expected value, plus a scan for any strictly later active
    // checkpoint matching the bus (lowest index wins, so exp[step] itself is
    // excluded and duplicates of it never count as out-of-order).
    always_comb begin
        exp_cur   = '0;
        later_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (step_q == IDXW'(k)) exp_cur = mem[k];
            if (IDXW'(k) > step_q && IDXW'(k) < len_q && sample == mem[k])
                later_hit = 1'b1;
        end
    end

    assign hit         = (sample == exp_cur);
    assign cnt_inc     = cnt_q + 1'b1;
    assign advance     = hit && (cnt_inc == CNT_W'(STABLE));
    assign order_err   = (STRICT != 0) && later_hit && !hit;
    assign wd_inc      = (wd_q == '1) ? wd_q : wd_q + 1'b1;
    assign timeout     = (lim_q != '0) && (wd_inc == lim_q);
    assign len_clamped = (seq_len > IDXW'(DEPTH)) ? IDXW'(DEPTH) : seq_len;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            lim_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            lim_q   <= lim_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
        end
    end

    // Same-cycle priority: abort > advance > ORDER > TIMEOUT; start is only
    // looked at outside WAIT.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        lim_d   = lim_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        code_d  = code_q;

        if (abort) begin
            state_d = S_IDLE;
            step_d  = '0;
            cnt_d   = '0;
            wd_d    = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            code_d  = CODE_NONE;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (advance) begin
                        step_d = step_q + 1'b1;
                        cnt_d  = '0;
                        wd_d   = '0;
                        if (step_q == len_q - 1'b1) begin
                            state_d = S_PASS;
                            pass_d  = 1'b1;
                        end
                    end else if (order_err) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                        code_d  = CODE_ORDER;
                        cnt_d   = '0;
                    end else if (timeout) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                        code_d  = CODE_TMO;
                        wd_d    = wd_inc;
                    end else begin
                        cnt_d = hit ? cnt_inc : '0;
                        wd_d  = wd_inc;
                    end
                end
                default: begin
                    if (start) begin
                        len_d  = len_clamped;
                        lim_d  = tmo_limit;
                        step_d = '0;
                        cnt_d  = '0;
                        wd_d   = '0;
                        pass_d = 1'b0;
                        fail_d = 1'b0;
                        code_d = CODE_NONE;
                        if (len_clamped == '0) begin
                            state_d = S_PASS;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = (state_q == S_WAIT);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = code_q;
    assign step      = step_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// tb_checkpoint_seq_monitor
//   Directed bench for checkpoint_seq_monitor. Two instances share all
//   stimulus: one with default ordering, one with STRICT=1.
module tb_checkpoint_seq_monitor;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int TMO_W = 24;
    localparam int IDXW  = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             resetb;
    logic [WIDTH-1:0] sample;
    logic             cfg_we;
    logic [IDXW-1:0]  cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic [IDXW-1:0]  seq_len;
    logic [TMO_W-1:0] tmo_limit;
    logic             start;
    logic             abort;

    logic             busy, pass, fail;
    logic [1:0]       fail_code;
    logic [IDXW-1:0]  step;
    logic             busy_s, pass_s, fail_s;
    logic [1:0]       fail_code_s;
    logic [IDXW-1:0]  step_s;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_W(TMO_W),
                             .STABLE(2), .STRICT(0)) dut (
        .clock(clock), .resetb(resetb), .sample(sample), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .seq_len(seq_len),
        .tmo_limit(tmo_limit), .start(start), .abort(abort), .busy(busy),
        .pass(pass), .fail(fail), .fail_code(fail_code), .step(step)
    );

    checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_W(TMO_W),
                             .STABLE(2), .STRICT(1)) dut_s (
        .clock(clock), .resetb(resetb), .sample(sample), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .seq_len(seq_len),
        .tmo_limit(tmo_limit), .start(start), .abort(abort), .busy(busy_s),
        .pass(pass_s), .fail(fail_s), .fail_code(fail_code_s), .step(step_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [IDXW-1:0] a, input logic [WIDTH-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic arm(input logic [IDXW-1:0] len, input logic [TMO_W-1:0] lim);
        seq_len   = len;
        tmo_limit = lim;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        resetb = 1'b0; sample = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        seq_len = '0; tmo_limit = '0; start = 1'b0; abort = 1'b0;
        ticks(3);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_code", fail_code, 0);
        chk("rst_step", step, 0);
        resetb = 1'b1;
        tick();

        // T1: three checkpoints, each held five cycles
        load(0, 16'hAB40);
        load(1, 16'hAB41);
        load(2, 16'hAB51);
        load(4, 16'hFFFF);          // out-of-range address must not alias
        arm(3, 1000);
        chk("t1_busy", busy, 1);
        chk("t1_step0", step, 0);
        sample = 16'hAB40; ticks(1);
        chk("t1_hold1", step, 0);
        ticks(1);
        chk("t1_step1", step, 1);
        ticks(3);
        sample = 16'hAB41; ticks(2);
        chk("t1_step2", step, 2);
        ticks(3);
        sample = 16'hAB51; ticks(1);
        chk("t1_busy_last", busy, 1);
        ticks(1);
        chk("t1_busy_drop", busy, 0);
        chk("t1_pass", pass, 1);
        chk("t1_step3", step, 3);
        chk("t1_pass_s", pass_s, 1);
        ticks(3);
        chk("t1_sticky", pass, 1);
        chk("t1_nofail", fail, 0);

        // T2: first checkpoint held only one cycle -> watchdog timeout
        sample = '0;
        arm(3, 1000);
        chk("t2_cleared", pass, 0);
        sample = 16'hAB40; ticks(1);
        sample = '0; ticks(998);
        chk("t2_busy999", busy, 1);
        chk("t2_nofail999", fail, 0);
        ticks(1);
        chk("t2_fail", fail, 1);
        chk("t2_code", fail_code, 1);
        chk("t2_step", step, 0);
        chk("t2_busy", busy, 0);
        chk("t2_code_s", fail_code_s, 1);

        // T4b: timeout one cycle before the final match completes
        arm(3, 4);
        sample = 16'hAB40; ticks(2);
        sample = 16'hAB41; ticks(2);
        sample = '0; ticks(3);
        sample = 16'hAB51; ticks(1);
        chk("t4b_fail", fail, 1);
        chk("t4b_code", fail_code, 1);
        chk("t4b_step", step, 2);

        // T4: final STABLE match lands on the timeout cycle -> advance wins
        sample = '0;
        arm(3, 4);
        chk("t4_armed", fail, 0);
        sample = 16'hAB40; ticks(2);
        sample = 16'hAB41; ticks(2);
        sample = '0; ticks(2);
        sample = 16'hAB51; ticks(2);
        chk("t4_pass", pass, 1);
        chk("t4_fail", fail, 0);
        chk("t4_step", step, 3);

        // T3: later checkpoint seen early
        sample = '0;
        arm(3, 1000);
        sample = 16'hAB51; ticks(1);
        chk("t3_fail_s", fail_s, 1);
        chk("t3_code_s", fail_code_s, 2);
        chk("t3_step_s", step_s, 0);
        chk("t3_busy_ns", busy, 1);
        chk("t3_fail_ns", fail, 0);
        sample = '0;
        do_abort();
        arm(3, 1000);
        sample = 16'hAB40; ticks(2);
        sample = 16'hAB51; ticks(1);
        chk("t3b_code_s", fail_code_s, 2);
        chk("t3b_step_s", step_s, 1);

        // T5: abort mid-WAIT, cfg_we ignored in WAIT, seq_len=0
        sample = '0;
        do_abort();
        chk("t5_abort_s_fail", fail_s, 0);
        arm(3, 1000);
        sample = 16'hAB40; ticks(2);
        chk("t5_step1", step, 1);
        do_abort();
        chk("t5_busy", busy, 0);
        chk("t5_pass", pass, 0);
        chk("t5_fail", fail, 0);
        chk("t5_step", step, 0);
        sample = '0;
        arm(3, 1000);
        load(0, 16'h1234);
        do_abort();
        arm(3, 1000);
        sample = 16'hAB40; ticks(2);
        chk("t5_ram_kept", step, 1);
        sample = '0;
        do_abort();
        arm(0, 1000);
        chk("t5_len0_pass", pass, 1);
        chk("t5_len0_busy", busy, 0);
        chk("t5_len0_step", step, 0);

        // seq_len above DEPTH clamps to DEPTH; exp[3] is still the reset value 0
        arm(7, 100);
        sample = 16'hAB40; ticks(2);
        sample = 16'hAB41; ticks(2);
        sample = 16'hAB51; ticks(2);
        chk("clamp_busy", busy, 1);
        sample = 16'h0000; ticks(2);
        chk("clamp_pass", pass, 1);
        chk("clamp_step", step, 4);

        // T6: asynchronous reset mid-WAIT
        arm(3, 1000);
        sample = 16'hAB40; ticks(2);
        chk("t6_pre_step", step, 1);
        #2;
        resetb = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_step", step, 0);
        chk("t6_pass", pass, 0);
        chk("t6_fail", fail, 0);
        chk("t6_code", fail_code, 0);
        tick();
        resetb = 1'b1;
        sample = '0;
        tick();
        arm(1, 100);
        ticks(2);
        chk("t6_ram_cleared", pass, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
